// File: rtl/binary_ops_arbiter.sv
// binary_ops_arbiter: round-robin shared AND/OR/XOR/XNOR unit with tagged registered response.
// Optional op_count statistics port enabled by BINARY_OPS_ARBITER_STATS_EN.
module binary_ops_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef BINARY_OPS_ARBITER_STATS_EN
  output logic [15:0]              op_count,
`endif
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic [ID_W-1:0]          resp_id
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic [ID_W-1:0] rr_ptr, g;
  logic found, can_accept, grant;
  logic [1:0] op;
  logic [WIDTH-1:0] a, b, res;
  always_comb begin
    g = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        g = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  assign can_accept = (state == IDLE) || (resp_ready && resp_valid);
  assign grant = can_accept && found;
  // req_ready must read zero while reset is held even though state already says IDLE
  always_comb begin
    req_ready = '0;
    if (rst_n && grant) req_ready[g] = 1'b1;
  end
  assign op = req_op[2*g +: 2];
  assign a = req_a[WIDTH*g +: WIDTH];
  assign b = req_b[WIDTH*g +: WIDTH];
  assign res = (op == 2'b00) ? (a & b) :
               (op == 2'b01) ? (a | b) :
               (op == 2'b10) ? (a ^ b) : ~(a ^ b);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_id <= '0;
      rr_ptr <= '0;
    end else if (grant) begin
      state <= HOLD;
      resp_valid <= 1'b1;
      resp_data <= res;
      resp_id <= g;
      rr_ptr <= (g == ID_W'(NUM_REQ - 1)) ? '0 : g + ID_W'(1);
    end else if (state == HOLD && resp_ready) begin
      state <= IDLE;
      resp_valid <= 1'b0;
    end
  end
`ifdef BINARY_OPS_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_count <= '0;
    else if (resp_valid && resp_ready && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_binary_ops_arbiter.sv
// tb_binary_ops_arbiter: directed checks of reset, opcodes, fairness, skip, backpressure and stats.
module tb_binary_ops_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid, req_ready;
  logic [7:0] req_op;
  logic [31:0] req_a, req_b;
  logic resp_valid, resp_ready;
  logic [7:0] resp_data;
  logic [1:0] resp_id;
`ifdef BINARY_OPS_ARBITER_STATS_EN
  logic [15:0] op_count;
`endif
  int checks = 0;
  int errors = 0;

  binary_ops_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef BINARY_OPS_ARBITER_STATS_EN
    .op_count(op_count),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_a(req_a),
    .req_b(req_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_id(resp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic grant_step(input string tag, input logic [3:0] rdy, input logic [1:0] id, input logic [7:0] data);
    #1 chk({tag, " req_ready"}, 32'(req_ready), 32'(rdy));
    @(posedge clk); #1;
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, " resp_id"}, 32'(resp_id), 32'(id));
    chk({tag, " resp_data"}, 32'(resp_data), 32'(data));
  endtask

  task automatic reset_checks(input string tag);
    #1;
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, " resp_data"}, 32'(resp_data), 32'd0);
    chk({tag, " resp_id"}, 32'(resp_id), 32'd0);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_op = 8'h5A;
    req_a = 32'hDEADBEEF;
    req_b = 32'h12345678;
    resp_ready = 1'b1;
    reset_checks("rst0");
    @(posedge clk); #1;
    rst_n = 1'b1;
    // opcodes on requester 0; other requesters carry junk that must not matter
    req_valid = 4'b0001;
    req_a = 32'hAAAA_AAF0;
    req_b = 32'h5555_553C;
    req_op = 8'b1110_0100;
    req_op[1:0] = 2'b00; grant_step("op_and", 4'b0001, 2'd0, 8'h30);
    req_op[1:0] = 2'b01; grant_step("op_or", 4'b0001, 2'd0, 8'hFC);
    req_op[1:0] = 2'b10; grant_step("op_xor", 4'b0001, 2'd0, 8'hCC);
    req_op[1:0] = 2'b11; grant_step("op_xnor", 4'b0001, 2'd0, 8'h33);
    // asynchronous reset while a response is pending
    #2;
    rst_n = 1'b0;
    req_valid = 4'b1111;
    reset_checks("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    // fairness: requester i computes i ^ 0x10
    req_op = 8'b1010_1010;
    req_a = 32'h03020100;
    req_b = 32'h10101010;
    req_valid = 4'b1111;
    for (int n = 0; n < 6; n++)
      grant_step("fair", 4'(1 << (n % 4)), 2'(n % 4), 8'h10 ^ 8'(n % 4));
    pulse_reset();
    req_valid = 4'b1010;
    grant_step("skip0", 4'b0010, 2'd1, 8'h11);
    grant_step("skip1", 4'b1000, 2'd3, 8'h13);
    grant_step("skip2", 4'b0010, 2'd1, 8'h11);
    grant_step("skip3", 4'b1000, 2'd3, 8'h13);
    req_valid = 4'b0010;
    grant_step("skip4", 4'b0010, 2'd1, 8'h11);
    grant_step("skip5", 4'b0010, 2'd1, 8'h11);
    // backpressure
    pulse_reset();
    req_valid = 4'b0001;
    grant_step("bp_first", 4'b0001, 2'd0, 8'h10);
    resp_ready = 1'b0;
    req_valid = 4'b0110;
    for (int n = 0; n < 3; n++) begin
      #1 chk("bp req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk("bp resp_valid", 32'(resp_valid), 32'd1);
      chk("bp resp_id", 32'(resp_id), 32'd0);
      chk("bp resp_data", 32'(resp_data), 32'h10);
    end
    resp_ready = 1'b1;
    grant_step("bp_g1", 4'b0010, 2'd1, 8'h11);
    grant_step("bp_g2", 4'b0100, 2'd2, 8'h12);
    req_valid = 4'b0000;
    #1 chk("drain req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("drain resp_valid", 32'(resp_valid), 32'd0);
    chk("drain resp_id", 32'(resp_id), 32'd2);
    chk("drain resp_data", 32'(resp_data), 32'h12);
`ifdef BINARY_OPS_ARBITER_STATS_EN
    pulse_reset();
    #1 chk("stats reset", 32'(op_count), 32'd0);
    req_valid = 4'b0001;
    repeat (5) begin @(posedge clk); #1; end
    req_valid = 4'b0000;
    @(posedge clk); #1;
    chk("stats five", 32'(op_count), 32'd5);
    force dut.op_count = 16'hFFFF;
    #1 release dut.op_count;
    req_valid = 4'b0001;
    repeat (2) begin @(posedge clk); #1; end
    req_valid = 4'b0000;
    @(posedge clk); #1;
    chk("stats sat", 32'(op_count), 32'hFFFF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
